ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//   Parametrised PS/2 device-to-host receiver with a first-word-fall-through scan-code FIFO.
//   - Synchronises and deglitches ps2_clk/ps2_data.
//   - Deframes 11-bit frames and checks start, parity and stop.
//   - Recovers from stalled frames by timeout.
//   - Sits between the keyboard pins and the keycode decoder/display logic; counts F0 break codes.
// PARAMETERS
//   FIFO_DEPTH      8      scan-code entries; power of 2, >= 2
//   SYNC_STAGES     3      flops in each pin synchroniser, >= 2
//   FILTER_LEN      4      consecutive equal ps2_clk samples needed to change filtered level, >= 1
//   TIMEOUT_CYCLES  50000  clk cycles without a falling edge that abort a partial frame
// PORTS
//   clk         in   1   system clock
//   rst         in   1   asynchronous reset, active-high
//   ps2_clk     in   1   PS/2 clock pin, asynchronous
//   ps2_data    in   1   PS/2 data pin, asynchronous
//   rd_en       in   1   pop request; honoured only when valid=1
//   data        out  8   FIFO head scan code; meaningful only when valid=1
//   valid       out  1   FIFO non-empty
//   level       out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//   overflow    out  1   sticky: a good frame was dropped because the FIFO was full
//   parity_err  out  1   sticky: frame dropped for even parity
//   frame_err   out  1   sticky: frame dropped for a bad start/stop bit, or aborted by timeout
//   err_clr     in   1   one-cycle pulse that clears the three sticky flags
//   break_cnt   out  8   count of 8'hF0 codes popped; wraps 255->0
// BEHAVIOUR
//   Reset (async assert, release synchronous to clk):
//     - data=0, valid=0, level=0, all flags=0, break_cnt=0.
//     - Pointers, bit counter and timeout counter are cleared; synchronisers and filter are set to 1 (idle bus).
//     - Reset mid-frame discards the partial frame.
//   Input conditioning:
//     - Both pins pass through SYNC_STAGES flops.
//     - The filtered clock toggles only after FILTER_LEN consecutive samples differ from its current level.
//     - sample = 1-cycle pulse on a falling edge of the filtered clock; it captures synchronised ps2_data.
//   Deframer (bit counter 0..10):
//     - Bit 0 is start (must be 0); bits 1-8 are data, LSB first; bit 9 is odd parity; bit 10 is stop (must be 1).
//     - On the bit-10 sample, exactly one outcome applies, with priority:
//       1. Start/stop bad -> frame_err=1, no push.
//       2. Otherwise parity even -> parity_err=1, no push.
//       3. Otherwise push.
//     - The counter returns to 0 for every outcome.
//     - Timeout: a counter increments each clk while bit counter != 0 and clears on each sample.
//       At TIMEOUT_CYCLES: bit counter=0, frame_err=1, no push. Idle (counter=0) never times out.
//   FIFO (registered push, FWFT read):
//     - A push writes in the cycle after the bit-10 sample; valid/data reflect it one cycle later.
//       Total latency from the bit-10 sample to valid is 2 clk.
//     - pop = rd_en & valid: advances the read pointer, decrements level, and next cycle presents the new head (or valid=0).
//       rd_en while empty is ignored.
//     - On pop, if head==8'hF0 then break_cnt increments.
//     - Push while full with no pop: byte dropped, overflow=1, contents unchanged.
//     - Push and pop in the same cycle when full: both take effect, level unchanged, no overflow.
//     - Push and pop in the same cycle when empty: push only, because valid=0 makes it not a pop.
//     - Pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
//   Sticky flags:
//     - A flag holds once set, until err_clr or rst.
//     - If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
// TESTING
//   1. Frame 0x1C (start0, bits 0,0,1,1,1,0,0,0, parity 0, stop1) -> valid=1, data=8'h1C, level=1, no flags.
//   2. Push 8 codes 0x01..0x08 with no reads, then a 9th frame 0x09 -> level=8, overflow=1;
//      8 pops return 0x01..0x08 in order, then valid=0.
//   3. Frame 0x1C with parity bit 1 -> parity_err=1, valid stays 0.
//      Then err_clr pulse -> parity_err=0.
//   4. Send 4 bits, then hold ps2_clk high for TIMEOUT_CYCLES+10 -> frame_err=1;
//      a following good frame 0x5A is received as data=8'h5A.
//   5. Codes F0,1C,F0,1C pushed and popped -> break_cnt=2.
//      With FIFO full, a push coincides with a pop -> level stays 8, overflow=0.
//   6. 1-cycle low glitches on ps2_clk (FILTER_LEN=4) during idle -> no sample, no flags.
//      Assert rst mid-frame -> all outputs 0; the next full frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with FWFT scan-code FIFO
//
// Purpose:
//   Synchronises and deglitches the PS/2 pins, deframes 11-bit frames
//   (start, 8 data LSB first, odd parity, stop), aborts stalled frames by
//   timeout and queues good scan codes in a first-word-fall-through FIFO.
//   Counts 8'hF0 break codes as they are popped.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   ps2_clk/data    asynchronous PS/2 pins
//   rd_en           pop request, honoured only while valid
//   data, valid     FIFO head and non-empty indication
//   level           FIFO occupancy
//   overflow        sticky: good frame dropped because FIFO full
//   parity_err      sticky: frame dropped for even parity
//   frame_err       sticky: bad start/stop or timeout abort
//   err_clr         clears the three sticky flags
//   break_cnt       number of 8'hF0 codes popped, wrapping

module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            rd_en,
    output logic [7:0]                      data,
    output logic                            valid,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            overflow,
    output logic                            parity_err,
    output logic                            frame_err,
    input  logic                            err_clr,
    output logic [7:0]                      break_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // ------------------------------------------------------------------
    // Pin synchronisers (reset to idle-high bus)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_s, data_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Clock filter: level flips only after FILTER_LEN consecutive
    // disagreeing samples; any agreeing sample restarts the run.
    // ------------------------------------------------------------------
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          sample;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Falling edge of the filtered clock, seen in the cycle it flips.
    assign sample = filt_q & ~filt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Deframer and stall timeout
    // ------------------------------------------------------------------
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shift_q, shift_d;     // after 10 shifts: [0]=start, [8:1]=data, [9]=parity
    logic [TW-1:0] to_q, to_d;
    logic          push_q, push_d;
    logic [7:0]    pdata_q, pdata_d;
    logic          frame_set, par_set;

    always_comb begin
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        to_d      = to_q;
        push_d    = 1'b0;
        pdata_d   = pdata_q;
        frame_set = 1'b0;
        par_set   = 1'b0;
        if (sample) begin
            to_d = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d = 4'd0;
                if (shift_q[0] | ~data_s) begin
                    frame_set = 1'b1;
                end else if (~^shift_q[9:1]) begin
                    par_set = 1'b1;
                end else begin
                    push_d  = 1'b1;
                    pdata_d = shift_q[8:1];
                end
            end else begin
                shift_d  = {data_s, shift_q[9:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bitcnt_d  = 4'd0;
                to_d      = '0;
                frame_set = 1'b1;
            end else begin
                to_d = to_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt_q <= '0;
            shift_q  <= '0;
            to_q     <= '0;
            push_q   <= 1'b0;
            pdata_q  <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            to_q     <= to_d;
            push_q   <= push_d;
            pdata_q  <= pdata_d;
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    brk_q, brk_d;
    logic          full, pop, wr, ovf_set;

    assign valid   = (level_q != '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign pop     = rd_en & valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr      = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        brk_d    = brk_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (mem_q[rd_ptr_q] == 8'hF0) begin
                brk_d = brk_q + 8'd1;
            end
        end
        if (wr && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !wr) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= pdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            brk_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            brk_q    <= brk_d;
        end
    end

    assign data      = valid ? mem_q[rd_ptr_q] : 8'h00;
    assign level     = level_q;
    assign break_cnt = brk_q;

    // ------------------------------------------------------------------
    // Sticky flags: a new error in the clear cycle wins.
    // ------------------------------------------------------------------
    logic ovf_q, ovf_d, par_q, par_d, frm_q, frm_d;

    always_comb begin
        ovf_d = (ovf_q & ~err_clr) | ovf_set;
        par_d = (par_q & ~err_clr) | par_set;
        frm_d = (frm_q & ~err_clr) | frame_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            par_q <= 1'b0;
            frm_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            par_q <= par_d;
            frm_q <= frm_d;
        end
    end

    assign overflow   = ovf_q;
    assign parity_err = par_q;
    assign frame_err  = frm_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo

module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TO    = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [3:0] level;
    logic       overflow, parity_err, frame_err;
    logic [7:0] break_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ps2_rx_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .SYNC_STAGES   (3),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data      (data),
        .valid     (valid),
        .level     (level),
        .overflow  (overflow),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .err_clr   (err_clr),
        .break_cnt (break_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(5);
        ps2_clk = 1'b0;
        tick(10);
        ps2_clk = 1'b1;
        tick(5);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        send_bit(stop);
        ps2_data = 1'b1;
        tick(6);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, {valid, data}, {1'b1, exp});
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_level", level, 0);
        check("rst_flags", {overflow, parity_err, frame_err}, 0);
        check("rst_brk", break_cnt, 0);
        rst = 1'b0;
        tick(3);

        // 1: single good frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t1_valid", valid, 1);
        check("t1_data", data, 8'h1C);
        check("t1_level", level, 1);
        check("t1_flags", {overflow, parity_err, frame_err}, 0);
        pop_expect("t1_pop", 8'h1C);
        check("t1_empty", {valid, level}, 0);
        rd_en = 1'b1;                    // pop while empty must be ignored
        tick(1);
        rd_en = 1'b0;
        check("t1_empty_pop", {valid, level}, 0);

        // 2: fill to 8, ninth frame overflows
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1);
        check("t2_full_level", level, 8);
        check("t2_no_ovf_yet", overflow, 0);
        send_frame(8'h09, 1'b0, 1'b1);
        check("t2_level", level, 8);
        check("t2_ovf", overflow, 1);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("t2_pop%0d", i), 8'(i));
        check("t2_drained", {valid, level}, 0);
        clear_errs();
        check("t2_ovf_clr", overflow, 0);

        // 3: parity error, then clear
        send_frame(8'h1C, 1'b1, 1'b1);
        check("t3_par", parity_err, 1);
        check("t3_valid", valid, 0);
        check("t3_frm", frame_err, 0);
        clear_errs();
        check("t3_par_clr", parity_err, 0);

        // 3b: bad stop bit
        send_frame(8'h33, 1'b0, 1'b0);
        check("t3b_frm", frame_err, 1);
        check("t3b_valid", valid, 0);
        clear_errs();

        // 4: stall after 4 bits -> timeout
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        tick(TO - 40);
        check("t4_early", frame_err, 0);
        tick(50);
        check("t4_timeout", frame_err, 1);
        clear_errs();
        send_frame(8'h5A, 1'b0, 1'b1);
        check("t4_data", {valid, data}, {1'b1, 8'h5A});
        check("t4_flags", {parity_err, frame_err}, 0);
        pop_expect("t4_pop", 8'h5A);

        // 5: break counting
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t5_level4", level, 4);
        pop_expect("t5_p0", 8'hF0);
        pop_expect("t5_p1", 8'h1C);
        pop_expect("t5_p2", 8'hF0);
        pop_expect("t5_p3", 8'h1C);
        check("t5_brk", break_cnt, 2);

        // 5b: full FIFO, push coincides with pop
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
        check("t5_full", level, 8);
        fork
            send_frame(8'h77, 1'b0, 1'b1);
            begin
                int k;
                k = 0;
                while (dut.push_q !== 1'b1 && k < 400) begin
                    tick(1);
                    k++;
                end
                check("t5_push_seen", dut.push_q, 1);
                check("t5_head", data, 8'h10);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end
        join
        check("t5_lvl_same", level, 8);
        check("t5_no_ovf", overflow, 0);
        for (int i = 1; i < 8; i++) pop_expect($sformatf("t5_q%0d", i), 8'h10 + 8'(i));
        pop_expect("t5_tail", 8'h77);
        check("t5_brk_keep", break_cnt, 2);

        // 6: single-cycle glitches while idle
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            tick(1);
            ps2_clk = 1'b1;
            tick(6);
        end
        check("t6_glitch", {valid, level, overflow, parity_err, frame_err}, 0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("t6_after_glitch", {valid, data, frame_err}, {1'b1, 8'h29, 1'b0});
        pop_expect("t6_pop", 8'h29);

        // 6b: reset mid-frame
        send_frame(8'h44, 1'b0, 1'b1);   // leave one entry so reset visibly clears it
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        tick(2);
        check("t6_rst_out", {valid, data, level, overflow, parity_err, frame_err, break_cnt}, 0);
        rst = 1'b0;
        tick(3);
        send_frame(8'h3A, 1'b0, 1'b1);
        check("t6_post_rst", {valid, data, level}, {1'b1, 8'h3A, 4'd1});
        check("t6_post_flags", {overflow, parity_err, frame_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
